seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised Moore-type serial pattern detector for the sequence-detection datapath. It replaces the fixed alternating-bit detector with a runtime-loadable pattern of width PAT_W and a per-bit don't-care mask. It has a selectable overlapping or non-overlapping match mode, a `din_valid` qualifier and a saturating match counter. The block sits directly on a serial bit stream and reports a registered (Moore) match flag plus a running hit count.

## Interface
- `PAT_W`, default 8: pattern length in bits; legal range 2..32.
- `CNT_W`, default 8: width of the match counter.
- `DEFAULT_PAT`, default 8'b0101_0101: pattern loaded at reset. First-received bit is the MSB.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial data bit.
- `din_valid`  in  1  `din` is accepted on a rising edge only when high.
- `overlap`  in  1  1 = overlapping matches; 0 = history cleared after each match.
- `pat_load`  in  1  synchronous load of `pat_in`/`mask_in`.
- `pat_in`  in  PAT_W  new pattern, MSB = oldest bit.
- `mask_in`  in  PAT_W  per-bit compare enable; 1 = compare, 0 = don't care.
- `cnt_clr`  in  1  synchronous clear of `hit_cnt`.
- `flag`  out  1  registered match flag; high exactly while state = HIT.
- `hit_cnt`  out  CNT_W  matches since reset/clear; saturates at all-ones.
- `busy_fill`  out  1  high while state is EMPTY or FILL, i.e. history not yet full.

## Operation
- Registers:
  - `pat`, `mask`, `hist[PAT_W-1:0]` (newest bit at LSB)
  - fill counter (0..PAT_W)
  - 2-bit state
  - `hit_cnt`
- Candidate history on an accepted bit is `nhist = {hist[PAT_W-2:0], din}`.
- A match occurs when `((nhist ^ pat) & mask) == 0` and this bit brings the fill count to at least PAT_W.
- States and transitions; each transition happens only on an edge with `din_valid`=1 and `pat_load`=0:
  - EMPTY (fill=0): goes to FILL, fill=1.
  - FILL: fill increments. When fill reaches PAT_W, goes to HIT on a match, otherwise ARMED.
  - ARMED: goes to HIT on a match, otherwise stays ARMED.
  - HIT with `overlap`=1: goes to HIT on a match, otherwise ARMED.
  - HIT with `overlap`=0: the fill was already cleared at the match. The bit is shifted in with fill=1 and the state goes to FILL.
- On every match edge:
  - `hit_cnt` increments, saturating at 2^CNT_W-1.
  - If `overlap`=0 at that edge, the fill counter is set to 0; `hist` still takes `nhist`.
- `din_valid`=0: all state, history, fill and flag hold.
- `pat_load`=1:
  - `pat`←`pat_in`, `mask`←`mask_in`; `hist`←0, fill←0, state←EMPTY.
  - `hit_cnt` is unchanged.
  - A simultaneous valid bit is discarded (load wins).
- `cnt_clr`=1: `hit_cnt`←0. Clear wins over a simultaneous match, so the result is 0. State and flag still update normally.
- `mask`=0: every full-history accepted bit matches.
- Reset values:
  - state EMPTY, `flag`=0, `busy_fill`=1, `hit_cnt`=0
  - `hist`=0, fill=0
  - `pat`=DEFAULT_PAT, `mask`=all ones

## Timing
- All outputs are registered from state. There is no combinational path from inputs to outputs.
- Latency: the edge that accepts the completing bit sets `flag`=1 immediately after that edge, i.e. 0 cycles after the edge.
- `flag` stays high until the next accepted bit (or `pat_load`) moves the state out of HIT. Idle cycles extend it.
- `hit_cnt` updates on the same edge as the `flag` rise. Back-to-back overlapping matches keep `flag` high and increment `hit_cnt` once per match.
- First match is possible no earlier than the PAT_W-th accepted bit after reset or load.
- Non-overlap mode: the next match needs PAT_W further accepted bits.
- `rst_n` low mid-stream clears everything asynchronously. The first accepted bit after release counts as bit 1.

## Test plan
- **Default pattern:**
  - Stimulus: reset, `overlap`=1, feed 0,1,0,1,0,1,0,1 with valid every cycle.
  - Expected: `flag` rises after the 8th edge and `hit_cnt`=1.
  - Then feed 0: `flag`=0, state ARMED. Then feed 1: `flag`=1, `hit_cnt`=2.
- **Non-overlap:**
  - Stimulus: same 8 bits plus 0,1 with `overlap`=0.
  - Expected: after the 10th bit `flag`=0, `busy_fill`=1 and `hit_cnt`=1. The next match comes only after 8 more matching bits.
- **Valid gaps:**
  - Stimulus: insert `din_valid`=0 for 3 cycles between each bit of the pattern, and for 5 cycles after the match.
  - Expected: `flag` stays high through all 5 idle cycles and `hit_cnt`=1.
- **Load with mask:**
  - Stimulus: `pat_load` with `pat_in`=8'hF0, `mask_in`=8'hF0, while asserting `din_valid` on the same edge.
  - Expected: that bit is discarded.
  - Then feed 1,1,1,1,0,1,1,0: match on the 8th bit and `hit_cnt` continues from its prior value.
- **Counter:**
  - Stimulus: CNT_W=2, mask=0, `overlap`=1, feed 12 bits.
  - Expected: `hit_cnt` saturates at 3.
  - Then assert `cnt_clr` on a match edge: `hit_cnt`=0.
- **Reset mid-stream:**
  - Stimulus: drop `rst_n` after 6 matching bits.
  - Expected: `flag`=0, `hit_cnt`=0, `pat`=DEFAULT_PAT. A fresh 8-bit pattern is needed to match.

Source files
------------

// File: rtl/seq_detector_param.sv
// Moore serial pattern detector with a runtime-loadable pattern and don't-care mask,
// overlapping/non-overlapping match modes and a saturating hit counter.
module seq_detector_param #(
    parameter int                 PAT_W       = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [PAT_W-1:0]   DEFAULT_PAT = 8'b0101_0101
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [PAT_W-1:0] mask_in,
    input  logic             cnt_clr,
    output logic             flag,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             busy_fill
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2,
        HIT   = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [PAT_W-1:0]   pat, mask, hist;
    logic [PAT_W-1:0]   pat_n, mask_n, hist_n, nhist;
    logic [FILL_W-1:0]  fill, fill_n, fill_inc;
    logic [CNT_W-1:0]   cnt_n;
    logic               full, match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            pat     <= DEFAULT_PAT;
            mask    <= '1;
            hist    <= '0;
            fill    <= '0;
            hit_cnt <= '0;
        end else begin
            state   <= state_n;
            pat     <= pat_n;
            mask    <= mask_n;
            hist    <= hist_n;
            fill    <= fill_n;
            hit_cnt <= cnt_n;
        end
    end

    // Fill saturates at PAT_W; the state follows from the fill level, so a
    // non-overlap match (fill cleared) naturally drops back into FILL.
    always_comb begin
        nhist    = {hist[PAT_W-2:0], din};
        fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
        full     = (fill_inc == FILL_FULL);
        match    = full && (((nhist ^ pat) & mask) == '0);

        state_n = state;
        pat_n   = pat;
        mask_n  = mask;
        hist_n  = hist;
        fill_n  = fill;
        cnt_n   = hit_cnt;

        if (pat_load) begin
            pat_n   = pat_in;
            mask_n  = mask_in;
            hist_n  = '0;
            fill_n  = '0;
            state_n = EMPTY;
        end else if (din_valid) begin
            hist_n = nhist;
            if (match) begin
                state_n = HIT;
                fill_n  = overlap ? fill_inc : '0;
                if (hit_cnt != CNT_MAX)
                    cnt_n = hit_cnt + 1'b1;
            end else begin
                state_n = full ? ARMED : FILL;
                fill_n  = fill_inc;
            end
        end

        // Clear wins over any simultaneous increment.
        if (cnt_clr)
            cnt_n = '0;
    end

    assign flag      = (state == HIT);
    assign busy_fill = (state == EMPTY) || (state == FILL);

endmodule
